// File: rtl/commit_trace_pkg.sv
// Shared definitions for the commit trace monitor: flag bit positions and
// record field offsets derived from the configured widths.
package commit_trace_pkg;

  localparam int NUM_FLAGS = 4;
  localparam int FLG_HALT  = 3;
  localparam int FLG_REGWE = 2;
  localparam int FLG_MEMRE = 1;
  localparam int FLG_MEMWE = 0;

  function automatic int rec_w(input int addr_w, input int reg_aw, input int data_w);
    return NUM_FLAGS + 2 * addr_w + reg_aw + 2 * data_w;
  endfunction

  // Offsets are LSB positions; mem_data sits at bit 0.
  function automatic int off_mem_addr(input int data_w);
    return data_w;
  endfunction

  function automatic int off_reg_data(input int addr_w, input int data_w);
    return data_w + addr_w;
  endfunction

  function automatic int off_reg_addr(input int addr_w, input int data_w);
    return 2 * data_w + addr_w;
  endfunction

  function automatic int off_pc(input int addr_w, input int reg_aw, input int data_w);
    return 2 * data_w + addr_w + reg_aw;
  endfunction

  function automatic int off_flags(input int addr_w, input int reg_aw, input int data_w);
    return 2 * data_w + 2 * addr_w + reg_aw;
  endfunction

endpackage

// File: rtl/commit_trace_monitor_sync_fifo.sv
// Synchronous FIFO with a registered head word; a pushed entry becomes
// visible at the head one cycle after the push edge, never combinationally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = head_q;

  always_comb begin
    rd_d   = rd_q + PW'(do_pop);
    wr_d   = wr_q + PW'(do_push);
    cnt_d  = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    head_d = '0;
    // The word being written this edge lands at the head when it is the only one left.
    if (cnt_d != '0) begin
      if (do_push && (rd_d == wr_q)) head_d = wdata;
      else                           head_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/commit_trace_monitor.sv
// Commit-event monitor: packs each active commit cycle into a trace record,
// buffers records in a FIFO and keeps counters plus sticky halt/timeout/overflow.
module commit_trace_monitor
  import commit_trace_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int REG_AW     = 4,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 100000,
  localparam int REC_W     = rec_w(ADDR_W, REG_AW, DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] pc,
  input  logic              reg_we,
  input  logic [REG_AW-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              halt,
  output logic              trc_valid,
  input  logic              trc_ready,
  output logic [REC_W-1:0]  trc_data,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              halted,
  output logic              timeout,
  output logic              overflow
);

  localparam int OFF_MEM_ADDR = off_mem_addr(DATA_W);
  localparam int OFF_REG_DATA = off_reg_data(ADDR_W, DATA_W);
  localparam int OFF_REG_ADDR = off_reg_addr(ADDR_W, DATA_W);
  localparam int OFF_PC       = off_pc(ADDR_W, REG_AW, DATA_W);
  localparam int OFF_FLAGS    = off_flags(ADDR_W, REG_AW, DATA_W);
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MAX_CYCLES - 1);

  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] inst_count_q, inst_count_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;
  logic             halted_q, halted_d, timeout_q, timeout_d, overflow_q, overflow_d;
  logic [REC_W-1:0] trc_rec;
  logic             active, evt, retire, push_req, pop, drop, fifo_full, fifo_empty;

  assign active   = en & ~halted_q & ~timeout_q;
  assign evt      = halt | reg_we | mem_re | mem_we;
  assign retire   = halt | reg_we | mem_we;
  assign push_req = active & evt;
  assign pop      = trc_valid & trc_ready;
  assign drop     = push_req & fifo_full & ~pop;

  always_comb begin
    trc_rec = '0;
    trc_rec[OFF_FLAGS + FLG_HALT]  = halt;
    trc_rec[OFF_FLAGS + FLG_REGWE] = reg_we;
    trc_rec[OFF_FLAGS + FLG_MEMRE] = mem_re;
    trc_rec[OFF_FLAGS + FLG_MEMWE] = mem_we;
    trc_rec[OFF_PC +: ADDR_W]      = pc;
    if (reg_we) begin
      trc_rec[OFF_REG_ADDR +: REG_AW] = reg_addr;
      trc_rec[OFF_REG_DATA +: DATA_W] = reg_data;
    end
    if (mem_re | mem_we) trc_rec[OFF_MEM_ADDR +: ADDR_W] = mem_addr;
    if (mem_we)      trc_rec[0 +: DATA_W] = mem_wdata;
    else if (mem_re) trc_rec[0 +: DATA_W] = mem_rdata;
  end

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .wdata (trc_rec),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (trc_data)
  );

  assign trc_valid = ~fifo_empty;

  always_comb begin
    cycle_count_d = cycle_count_q;
    inst_count_d  = inst_count_q;
    drop_count_d  = drop_count_q;
    halted_d      = halted_q;
    timeout_d     = timeout_q;
    overflow_d    = overflow_q;
    if (active) begin
      // Watchdog compares the pre-increment count; the expiring cycle still captures.
      if (cycle_count_q == WD_LIMIT) timeout_d = 1'b1;
      if (cycle_count_q != '1) cycle_count_d = cycle_count_q + 1'b1;
      if (retire && (inst_count_q != '1)) inst_count_d = inst_count_q + 1'b1;
      if (halt) halted_d = 1'b1;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != '1) drop_count_d = drop_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count_q <= '0;
      inst_count_q  <= '0;
      drop_count_q  <= '0;
      halted_q      <= 1'b0;
      timeout_q     <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      cycle_count_q <= cycle_count_d;
      inst_count_q  <= inst_count_d;
      drop_count_q  <= drop_count_d;
      halted_q      <= halted_d;
      timeout_q     <= timeout_d;
      overflow_q    <= overflow_d;
    end
  end

  assign cycle_count = cycle_count_q;
  assign inst_count  = inst_count_q;
  assign drop_count  = drop_count_q;
  assign halted      = halted_q;
  assign timeout     = timeout_q;
  assign overflow    = overflow_q;

endmodule

// File: doc/commit_trace_monitor.md
Name: commit_trace_monitor

Overview:
Synthesizable, parametrised commit-event monitor for the pipelined CPU. It samples the writeback/memory-stage commit signals every cycle and packs each active cycle into one trace record. Records are buffered in a FIFO drained over a valid/ready port. It also keeps cycle, retired-instruction and dropped-record counters, and provides sticky halt and watchdog-timeout flags, so on-chip and bench tracing share one source.

Parameters:
DATA_W, 16, register/memory data width
ADDR_W, 16, PC and memory address width
REG_AW, 4, register index width
DEPTH, 16, trace FIFO entries (power of two, >=2)
CNT_W, 32, width of all counters
MAX_CYCLES, 100000, watchdog limit in cycles after reset release

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  capture/count enable
pc  in  ADDR_W  PC of the committing instruction
reg_we  in  1  register file write this cycle
reg_addr  in  REG_AW  destination register
reg_data  in  DATA_W  register write data
mem_re  in  1  data memory read this cycle
mem_we  in  1  data memory write this cycle
mem_addr  in  ADDR_W  data memory address
mem_wdata  in  DATA_W  store data
mem_rdata  in  DATA_W  load data
halt  in  1  halt reached memory/writeback
trc_valid  out  1  FIFO head valid
trc_ready  in  1  consumer accepts head
trc_data  out  REC_W  head record, REC_W = 4+2*ADDR_W+REG_AW+2*DATA_W
cycle_count  out  CNT_W  cycles counted
inst_count  out  CNT_W  retired instructions
drop_count  out  CNT_W  records lost to a full FIFO
halted  out  1  sticky halt seen
timeout  out  1  sticky watchdog expiry
overflow  out  1  sticky: at least one drop

Behaviour:
- Decided: single clock clk; rst is synchronous and active-high.
- Reset: all counters 0; halted, timeout, overflow, trc_valid 0; FIFO empty; trc_data 0. rst mid-operation discards FIFO contents.
- active = en & ~halted & ~timeout. All capture and counting is gated by active.
- Record packing, MSB to LSB: {halt, reg_we, mem_re, mem_we, pc, reg_addr, reg_data, mem_addr, mem_data}.
  - mem_data = mem_wdata if mem_we, else mem_rdata.
  - Fields whose flag is clear are forced to 0.
- event = halt | reg_we | mem_re | mem_we. On an active event cycle, one record is pushed at that posedge.
  - trc_valid rises the next cycle. There is no same-cycle bypass.
- cycle_count increments every active cycle. inst_count increments on active cycles with halt | reg_we | mem_we; a load-only cycle does not count. Both counters saturate at all-ones.
- Pop: occurs when trc_valid & trc_ready. The head advances, and the next entry is visible the following cycle.
- Full FIFO with a push and no pop: the record is dropped, drop_count increments (saturating), and overflow is set.
- Full FIFO with simultaneous push and pop: both occur, with no drop.
- Empty FIFO with trc_ready high: no effect.
- Halt: the halt cycle's record is pushed (subject to full), and halted is set at that edge. All later capture and counting stop until rst. The FIFO keeps draining.
- Watchdog: the comparison is made against the cycle_count value at the start of an active cycle. In the active cycle where cycle_count == MAX_CYCLES-1:
  - cycle_count increments to MAX_CYCLES;
  - timeout is set;
  - any event in that same cycle is still captured.
  - Capture stops afterwards. halt and timeout in the same cycle set both flags.
- en low: inputs are ignored and the FIFO still drains.

Decomposition:
- Shared package commit_trace_pkg holds the flag bit positions (FLG_HALT=3, FLG_REGWE=2, FLG_MEMRE=1, FLG_MEMWE=0), field offset localparams derived from the widths, and a REC_W function.
- One sub-module, sync_fifo:
  - parameters WIDTH and DEPTH;
  - synchronous active-high rst;
  - push/pop/full/empty interface with a registered head.
- Counters and flags stay in the top module.

Test Plan:
1. reg_we=1, reg_addr=3, reg_data=0x1234, pc=0x0010, trc_ready=1 -> one cycle later trc_valid=1 with flags=4'b0100 and the fields matched; inst_count=1.
2. Load-only cycle: mem_re=1, mem_addr=0x0040, mem_rdata=0xBEEF -> record flags=4'b0010, mem_data=0xBEEF; inst_count unchanged.
3. trc_ready=0 and 20 consecutive reg_we cycles with DEPTH=16 -> 16 records buffered; drop_count=4, overflow=1; draining returns the first 16 in order.
4. Full FIFO with simultaneous push and pop -> drop_count unchanged; occupancy stays 16.
5. halt=1 at cycle 50, then reg_we pulses -> halt record present; halted=1; cycle_count frozen at 50; inst_count excludes later pulses.
6. MAX_CYCLES=8, en=1, no halt -> timeout=1 after the 8th active cycle; cycle_count=8. Then rst=1 for one cycle -> all outputs return to reset values.
